// File: rtl/parity_rr_scheduler.sv
// rtl/parity_rr_scheduler.sv - round-robin arbiter feeding a shared registered parity unit
// One request is in flight at a time: IDLE grants, CALC computes parity, RESP holds the result.
module parity_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  input  logic [NREQ-1:0]            req_odd,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_parity,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic           grant;
  logic           mode_q;

  // Scan starting at ptr and wrapping modulo NREQ; first valid requester wins.
  always_comb begin : arbiter
    logic [IDW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant = (state == IDLE) && found;
  assign busy  = (state != IDLE);

  // Held low while reset is asserted so no requester sees a spurious accept.
  always_comb begin
    req_ready = '0;
    if (rst_n && grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      mode_q     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_parity <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            rsp_data <= req_data[winner*WIDTH +: WIDTH];
            mode_q   <= req_odd[winner];
            rsp_id   <= winner;
            ptr      <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        CALC: begin
          rsp_parity <= (^rsp_data) ^ mode_q;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule
